// File: rtl/register_bank_mb.sv
// Multi-context register bank: register 0 (PC) is shared, registers 1..NUM_REGS-1 are banked.
// Optional same-cycle write-to-read forwarding when REG_BANK_BYPASS_EN is defined (ADDR_WIDTH >= 2 assumed).
//
//   state  | meaning
//   IDLE   | normal operation; writes, bank switches and bypass allowed
//   SWITCH | one-cycle settle after a bank change; writes and ctx_sw dropped, pc_inc honoured
module register_bank_mb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_BANKS  = 2,
  localparam int NUM_REGS  = 2 ** ADDR_WIDTH,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bank_wr_en,
  input  logic [ADDR_WIDTH-1:0] busC_addr,
  input  logic [DATA_WIDTH-1:0] busC,
  input  logic [ADDR_WIDTH-1:0] busA_addr,
  input  logic [ADDR_WIDTH-1:0] busB_addr,
  output logic [DATA_WIDTH-1:0] busA,
  output logic [DATA_WIDTH-1:0] busB,
  input  logic                  pc_inc,
  input  logic                  ctx_sw,
  input  logic [BANK_W-1:0]     ctx_sel,
  output logic                  ctx_busy,
  output logic [BANK_W-1:0]     active_bank,
  output logic [DATA_WIDTH-1:0] PC_m,
  output logic [DATA_WIDTH-1:0] DPTR_m,
  output logic [DATA_WIDTH-1:0] A_m,
  output logic [DATA_WIDTH-1:0] TEMP_m,
  output logic [DATA_WIDTH-1:0] ACC_m
);

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [BANK_W:0] NUM_BANKS_V = (BANK_W + 1)'(NUM_BANKS);

  typedef enum logic {IDLE = 1'b0, SWITCH = 1'b1} ctx_state_t;

  ctx_state_t            state, state_nx;
  logic [BANK_W-1:0]     bank_nx;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] bank_regs [NUM_BANKS][1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] act_regs [NUM_REGS];
  logic                  wr_eff;
  logic                  sw_ok;

  assign wr_eff = bank_wr_en && (state == IDLE);

  // A switch is accepted only to a different, existing bank.
  assign sw_ok = (NUM_BANKS > 1) && ctx_sw && (ctx_sel != active_bank)
                 && ({1'b0, ctx_sel} < NUM_BANKS_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      active_bank <= '0;
    end else begin
      state       <= state_nx;
      active_bank <= bank_nx;
    end
  end

  always_comb begin
    state_nx = state;
    bank_nx  = active_bank;
    case (state)
      IDLE: begin
        if (sw_ok) begin
          state_nx = SWITCH;
          bank_nx  = ctx_sel;
        end
      end
      SWITCH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ctx_busy = (state == SWITCH);

  // The write uses the pre-edge active_bank, so a write alongside a switch lands in the old bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int r = 1; r < NUM_REGS; r++) begin
          bank_regs[b][r] <= '0;
        end
      end
    end else begin
      if (wr_eff && (busC_addr == '0)) begin
        pc <= busC;
      end else if (pc_inc) begin
        pc <= pc + 1'b1;
      end
      if (wr_eff && (busC_addr != '0)) begin
        bank_regs[active_bank][busC_addr] <= busC;
      end
    end
  end

  always_comb begin
    act_regs[0] = pc;
    for (int i = 1; i < NUM_REGS; i++) begin
      act_regs[i] = bank_regs[active_bank][i];
    end
  end

  always_comb begin
    busA = act_regs[busA_addr];
    busB = act_regs[busB_addr];
    if (BYPASS && wr_eff && (busA_addr == busC_addr)) busA = busC;
    if (BYPASS && wr_eff && (busB_addr == busC_addr)) busB = busC;
  end

  assign PC_m   = act_regs[0];
  assign DPTR_m = act_regs[1];
  assign A_m    = act_regs[2];
  assign TEMP_m = act_regs[3];
  assign ACC_m  = act_regs[NUM_REGS-1];

endmodule

// File: tb/tb_register_bank_mb.sv
// Scoreboard bench for register_bank_mb: directed scenarios then random traffic against an array model.
module tb_register_bank_mb;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NB = 3;
  localparam int NR = 8;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          bank_wr_en;
  logic [AW-1:0] busC_addr;
  logic [DW-1:0] busC;
  logic [AW-1:0] busA_addr;
  logic [AW-1:0] busB_addr;
  logic [DW-1:0] busA;
  logic [DW-1:0] busB;
  logic          pc_inc;
  logic          ctx_sw;
  logic [BW-1:0] ctx_sel;
  logic          ctx_busy;
  logic [BW-1:0] active_bank;
  logic [DW-1:0] PC_m, DPTR_m, A_m, TEMP_m, ACC_m;

  always #5 clk = ~clk;

  register_bank_mb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) dut (
    .clk(clk), .rst(rst), .bank_wr_en(bank_wr_en), .busC_addr(busC_addr), .busC(busC),
    .busA_addr(busA_addr), .busB_addr(busB_addr), .busA(busA), .busB(busB),
    .pc_inc(pc_inc), .ctx_sw(ctx_sw), .ctx_sel(ctx_sel), .ctx_busy(ctx_busy),
    .active_bank(active_bank), .PC_m(PC_m), .DPTR_m(DPTR_m), .A_m(A_m),
    .TEMP_m(TEMP_m), .ACC_m(ACC_m)
  );

`ifdef REG_BANK_BYPASS_EN
  localparam bit TB_BYPASS = 1'b1;
`else
  localparam bit TB_BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] bus_a, bus_b, pc, dptr, a, temp, acc;
    logic          busy;
    logic [BW-1:0] bank;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: shared PC plus a per-bank array; index 0 of the array is unused.
  int m_pc;
  int m_mem [NB][NR];
  int m_bank;
  bit m_busy;

  function automatic int m_rd(input int b, input int a);
    return (a == 0) ? m_pc : m_mem[b][a];
  endfunction

  task automatic m_reset();
    m_pc = 0;
    m_bank = 0;
    m_busy = 0;
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < NR; r++) m_mem[b][r] = 0;
  endtask

  task automatic step(input bit r, input bit w, input int ac, input int d,
                      input int aa, input int ab, input bit inc, input bit sw, input int sel);
    exp_t e;
    bit wr_ok;
    @(posedge clk);
    #1;
    rst = r; bank_wr_en = w; busC_addr = AW'(ac); busC = DW'(d);
    busA_addr = AW'(aa); busB_addr = AW'(ab); pc_inc = inc; ctx_sw = sw; ctx_sel = BW'(sel);
    wr_ok = w && !m_busy;
    e.bus_a = DW'((TB_BYPASS && wr_ok && aa == ac) ? d : m_rd(m_bank, aa));
    e.bus_b = DW'((TB_BYPASS && wr_ok && ab == ac) ? d : m_rd(m_bank, ab));
    e.pc    = DW'(m_pc);
    e.dptr  = DW'(m_rd(m_bank, 1));
    e.a     = DW'(m_rd(m_bank, 2));
    e.temp  = DW'(m_rd(m_bank, 3));
    e.acc   = DW'(m_rd(m_bank, NR - 1));
    e.busy  = m_busy;
    e.bank  = BW'(m_bank);
    exp_q.push_back(e);
    if (r) begin
      m_reset();
    end else begin
      if (wr_ok && ac == 0) m_pc = d % 256;
      else if (inc) m_pc = (m_pc + 1) % 256;
      if (wr_ok && ac != 0) m_mem[m_bank][ac] = d % 256;
      if (!m_busy && sw && sel != m_bank && sel < NB) begin
        m_bank = sel;
        m_busy = 1;
      end else begin
        m_busy = 0;
      end
    end
  endtask

  task automatic idle(input int aa, input int ab);
    step(0, 0, 0, 0, aa, ab, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busA", 32'(busA), 32'(e.bus_a));
        chk("busB", 32'(busB), 32'(e.bus_b));
        chk("PC_m", 32'(PC_m), 32'(e.pc));
        chk("DPTR_m", 32'(DPTR_m), 32'(e.dptr));
        chk("A_m", 32'(A_m), 32'(e.a));
        chk("TEMP_m", 32'(TEMP_m), 32'(e.temp));
        chk("ACC_m", 32'(ACC_m), 32'(e.acc));
        chk("ctx_busy", 32'(ctx_busy), 32'(e.busy));
        chk("active_bank", 32'(active_bank), 32'(e.bank));
      end
    end
  end

  initial begin : driver
    rst = 1'b1; bank_wr_en = 1'b0; busC_addr = '0; busC = '0; busA_addr = '0;
    busB_addr = '0; pc_inc = 1'b0; ctx_sw = 1'b0; ctx_sel = '0;
    repeat (2) @(posedge clk);
    m_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // ACC write, then observe all monitors
    step(0, 1, 7, 8'hA5, 7, 0, 0, 0, 0);
    idle(7, 0);
    // PC wrap
    step(0, 1, 0, 8'hFF, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(0, 0);
    // write beats increment
    step(0, 1, 0, 8'h3C, 0, 0, 1, 0, 0);
    idle(0, 0);
    // banked write dropped while busy, old bank retained
    step(0, 1, 2, 8'h11, 2, 2, 0, 0, 0);
    step(0, 0, 0, 0, 2, 0, 0, 1, 1);
    step(0, 1, 2, 8'h22, 2, 0, 1, 1, 2);
    idle(2, 0);
    step(0, 0, 0, 0, 2, 0, 0, 1, 0);
    idle(2, 0);
    idle(2, 0);
    // write in the same cycle as a switch goes to the old bank
    step(0, 1, 3, 8'h77, 3, 3, 0, 1, 1);
    idle(3, 3);
    step(0, 0, 0, 0, 3, 0, 0, 1, 0);
    idle(3, 3);
    // read/write same address: bypass or old value
    step(0, 1, 3, 8'h5A, 3, 0, 0, 0, 0);
    step(0, 1, 0, 8'h44, 0, 3, 1, 0, 0);
    idle(3, 0);
    // out-of-range and same-bank switch requests
    step(0, 0, 0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(0, 0);
    // reset while switching
    step(0, 1, 5, 8'h99, 5, 0, 0, 1, 2);
    step(1, 1, 6, 8'h66, 6, 5, 1, 1, 1);
    idle(5, 6);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), $urandom_range(0, NR - 1),
           $urandom_range(0, 255), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/register_bank_mb.md
REGISTER_BANK_MB -- requirements
Module: register_bank_mb

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of every register and bus.
REQ-002 Parameter ADDR_WIDTH, default 3; NUM_REGS = 2**ADDR_WIDTH registers per bank.
REQ-003 Parameter NUM_BANKS, default 2, number of register contexts (minimum 1).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 bank_wr_en  input  1  write busC into register busC_addr of the active bank.
REQ-007 busC_addr  input  ADDR_WIDTH  write address.
REQ-008 busC  input  DATA_WIDTH  write data.
REQ-009 busA_addr, busB_addr  input  ADDR_WIDTH each  read addresses.
REQ-010 busA, busB  output  DATA_WIDTH each  combinational read data from the active bank.
REQ-011 pc_inc  input  1  increment the PC (register 0) by 1.
REQ-012 ctx_sw  input  1  request a bank switch to ctx_sel.
REQ-013 ctx_sel  input  clog2(NUM_BANKS), minimum 1  target bank of ctx_sw.
REQ-014 ctx_busy  output  1  high for exactly the cycle after an accepted ctx_sw.
REQ-015 active_bank  output  clog2(NUM_BANKS), minimum 1  current bank index.
REQ-016 PC_m, DPTR_m, A_m, TEMP_m, ACC_m  output  DATA_WIDTH each  monitors of registers 0, 1, 2, 3 and NUM_REGS-1 of the active bank.

Function
REQ-017 Register 0 (PC) is shared by all banks; registers 1 to NUM_REGS-1 are replicated per bank.
REQ-018 Writes take effect on the clock edge; without bypass, reads return the pre-edge value.
REQ-019 pc_inc adds 1 modulo 2**DATA_WIDTH; PC = all-ones wraps to 0.
REQ-020 When bank_wr_en is high with busC_addr = 0 in the same cycle as pc_inc, the write wins and the increment is dropped.
REQ-021 Context FSM has states IDLE and SWITCH: IDLE goes to SWITCH when ctx_sw is high and ctx_sel differs from active_bank, with active_bank updated at that edge; SWITCH always returns to IDLE after one cycle.
REQ-022 In SWITCH, ctx_busy = 1, bank_wr_en is ignored, ctx_sw is ignored, and pc_inc is still honoured.
REQ-023 ctx_sw with ctx_sel = active_bank is a no-op: the FSM stays in IDLE and ctx_busy stays 0.
REQ-024 ctx_sel >= NUM_BANKS is ignored: the FSM stays in IDLE and the bank is unchanged.
REQ-025 A write in the same cycle as an accepted ctx_sw targets the old bank.
REQ-026 With NUM_BANKS = 1, ctx_sw is ignored, active_bank = 0 and ctx_busy = 0.

Reset
REQ-027 On a rising edge with rst = 1, all registers in all banks are cleared to 0, active_bank = 0, the FSM enters IDLE and ctx_busy = 0.
REQ-028 rst overrides every simultaneous write, pc_inc or ctx_sw, including during SWITCH.

Configuration
REQ-029 With macro REG_BANK_BYPASS_EN defined, a read whose address equals busC_addr while bank_wr_en is effective returns busC in the same cycle; register 0 returns the write data rather than PC+1.
REQ-030 With REG_BANK_BYPASS_EN undefined, reads return stored values only, per REQ-018.
REQ-031 Bypass never applies while the FSM is in SWITCH.

Verification
REQ-032 Reset, then write 0xA5 to address 7 -> ACC_m = 0xA5 on the next cycle and all other monitors = 0x00.
REQ-033 PC written to 0xFF, then pc_inc for 2 cycles -> PC_m = 0x00, then 0x01.
REQ-034 Write 0x3C to address 0 with pc_inc in the same cycle -> PC_m = 0x3C.
REQ-035 Write A = 0x11 in bank 0, ctx_sw to bank 1, write A = 0x22 while ctx_busy = 1 -> A_m = 0x00 (write dropped); after returning to bank 0 -> A_m = 0x11.
REQ-036 With REG_BANK_BYPASS_EN defined: busA_addr = busC_addr = 3, busC = 0x5A, bank_wr_en = 1 -> busA = 0x5A in the same cycle; with the macro undefined -> busA = old value.
REQ-037 rst asserted during SWITCH -> next cycle active_bank = 0, ctx_busy = 0 and all monitors = 0x00.
